// File: rtl/spn_decrypt_if.sv
// Valid/ready bundle between a ciphertext producer, the SPN decryption core and a plaintext consumer.
`timescale 1ns/1ps
interface spn_decrypt_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [79:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/spn_decrypt.sv
// Iterative 4-round decryption of the 16-bit SPN cipher: key whitening on accept, one inverse round per clock.
`timescale 1ns/1ps
module spn_decrypt (
  input  logic          clk,
  input  logic          rst,
  spn_decrypt_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  rnd_q, rnd_d;
  logic [15:0] st_q, st_d;
  logic [79:0] key_q, key_d;

  function automatic logic [3:0] sinv4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'ha;
      4'h1: y = 4'h3;
      4'h2: y = 4'h9;
      4'h3: y = 4'he;
      4'h4: y = 4'h1;
      4'h5: y = 4'hd;
      4'h6: y = 4'hf;
      4'h7: y = 4'h4;
      4'h8: y = 4'hc;
      4'h9: y = 4'h5;
      4'ha: y = 4'h7;
      4'hb: y = 4'h2;
      4'hc: y = 4'h6;
      4'hd: y = 4'h8;
      4'he: y = 4'h0;
      default: y = 4'hb;
    endcase
    return y;
  endfunction

  function automatic logic [15:0] sinv16(input logic [15:0] x);
    return {sinv4(x[15:12]), sinv4(x[11:8]), sinv4(x[7:4]), sinv4(x[3:0])};
  endfunction

  // 4x4 bit transpose: output bit 4k+n takes input bit 4n+k.
  function automatic logic [15:0] perm(input logic [15:0] x);
    return {x[15], x[11], x[7], x[3],
            x[14], x[10], x[6], x[2],
            x[13], x[9],  x[5], x[1],
            x[12], x[8],  x[4], x[0]};
  endfunction

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    key_d   = key_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          st_d    = bus.in_data ^ bus.in_key[15:0];
          key_d   = bus.in_key;
          rnd_d   = 2'd0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        rnd_d = rnd_q + 2'd1;
        // First step undoes the unpermuted last encryption round.
        case (rnd_q)
          2'd0: st_d = sinv16(st_q) ^ key_q[31:16];
          2'd1: st_d = sinv16(perm(st_q)) ^ key_q[47:32];
          2'd2: st_d = sinv16(perm(st_q)) ^ key_q[63:48];
          default: begin
            st_d    = sinv16(perm(st_q)) ^ key_q[79:64];
            state_d = DONE;
          end
        endcase
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= 2'd0;
      st_q    <= 16'h0000;
      key_q   <= 80'h0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      key_q   <= key_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = st_q;

endmodule

// File: doc/spn_decrypt.md
# spn_decrypt

Iterative decryption core for the team's 16-bit, 4-round substitution-permutation network cipher. It accepts a ciphertext block and an 80-bit key over a valid/ready handshake, runs one inverse round per clock, and presents the recovered plaintext on a valid/ready output. It is the receive-side counterpart of the encryption datapath and shares that datapath's 4-bit S-box, key schedule and bit permutation.

## Interface
- No parameters. Block width 16, key width 80 and round count 4 are fixed by the cipher.
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ciphertext and key present
- in_ready  out  1  core idle and able to accept
- in_data  in  16  ciphertext
- in_key  in  80  round keys: K1=[79:64], K2=[63:48], K3=[47:32], K4=[31:16], K5=[15:0]
- out_valid  out  1  plaintext available
- out_ready  in  1  consumer takes plaintext
- out_data  out  16  plaintext

## Operation
- Cipher, for reference. Encryption rounds r=1..3 compute v = P(S(v xor Kr)). The last step computes c = S(v xor K4) xor K5.
- Inverse S-box S^-1, applied to all four nibbles in parallel: 0→a, 1→3, 2→9, 3→e, 4→1, 5→d, 6→f, 7→4, 8→c, 9→5, a→7, b→2, c→6, d→8, e→0, f→b.
- P is a 4x4 bit transpose: output bit 4*(j mod 4)+(j div 4) = input bit j, for j=0..15. P is self-inverse, so decryption uses P directly.
- State machine IDLE → ROUND → DONE → IDLE. A 2-bit round counter rnd is used only in ROUND.
- IDLE:
  - in_ready=1.
  - On in_valid: st ← in_data xor K5, and latch in_key into a key register. Set rnd=0 and go to ROUND.
- ROUND: one step per cycle.
  - rnd=0: st ← S^-1(st) xor K4.
  - rnd=1: st ← S^-1(P(st)) xor K3.
  - rnd=2: st ← S^-1(P(st)) xor K2.
  - rnd=3: st ← S^-1(P(st)) xor K1, then go to DONE.
  - rnd increments after each of the first three steps.
- DONE:
  - out_valid=1 and out_data=st, both held stable until out_ready.
  - On out_valid & out_ready, go to IDLE.
- Keys are always taken from the latched key register. in_key and in_data are ignored outside the accepting IDLE edge.
- in_valid asserted while busy (ROUND or DONE) is ignored and not queued. The producer must hold its data until in_ready.
- All XORs are bitwise on 16 bits. There is no carry arithmetic.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=16'h0000, st=0, rnd=0, key register=0.
- rst high on any edge, including mid-ROUND or in DONE, aborts the current block. The block is not output. Reset values appear the cycle after that edge.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- Latency:
  - Acceptance edge E0, then rounds on E1 to E4.
  - out_valid rises after E4, i.e. 4 cycles after acceptance.
- out_ready held high in DONE: handshake on E5, IDLE after E5, next acceptance no earlier than E6. Minimum 6 cycles per block.
- out_ready low in DONE: the core stalls indefinitely with out_data and out_valid unchanged.
- in_ready=0 from the cycle after acceptance until the cycle after the output handshake.

## Test plan
- Reset, then in_data=16'h0000 and in_key=80'h0 with out_ready=1 → out_valid rises exactly 4 cycles after acceptance, out_data=16'h03b2, in_ready back to 1 one cycle after the handshake.
- in_data=16'hffff and in_key with K5=16'hffff, others 0 → out_data=16'h03b2. Checks K5 placement.
- in_data=16'h0000 and in_key with K1=16'h1234, others 0 → out_data=16'h1186. Checks K1 placement.
- Hold out_ready=0 for 10 cycles in DONE while toggling in_valid, in_data and in_key → out_data stays 16'h03b2, out_valid stays 1, in_ready stays 0, nothing accepted. Release out_ready → single handshake.
- Pulse rst on the 2nd round edge → in_ready=1, out_valid=0, out_data=0 the next cycle. A fresh 16'h0000 / key-0 block then yields 16'h03b2.
- Random round-trip: random key and plaintext encrypted by the bench model, then decrypted by the core → out_data equals the original plaintext for 1000 blocks with random out_ready back-pressure.
